// File: rtl/eth_status_tx.sv
// Status frame generator for the MAC TX AXI-Stream port.
// Counts good/bad RX frames and sends header, seq and snapshots on request.
module eth_status_tx #(
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h020000000001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned PAYLOAD_LEN = 46
) (
  input  logic       clk_125,
  input  logic       rst,
  input  logic       send_req,
  input  logic       rx_good_frame,
  input  logic       rx_bad_frame,
  output logic [7:0] tx_axis_tdata,
  output logic       tx_axis_tkeep,
  output logic       tx_axis_tvalid,
  input  logic       tx_axis_tready,
  output logic       tx_axis_tlast,
  output logic       tx_axis_tuser,
  output logic       busy
);

  localparam int unsigned IW = 11;
  localparam logic [IW-1:0] LAST_IDX = IW'(13 + PAYLOAD_LEN);
  localparam logic [IW-1:0] HDR_LEN  = IW'(24);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          pending, pending_n;
  logic [15:0]   seq, seq_n;
  logic [31:0]   good_cnt, bad_cnt;
  logic [31:0]   snap_good, snap_bad;
  logic          snap_en;
  logic          hs, at_last;
  logic [191:0]  hdr;
  logic [4:0]    rev;

  assign tx_axis_tkeep  = 1'b1;
  assign tx_axis_tuser  = 1'b0;
  assign tx_axis_tvalid = (state == SEND);
  assign at_last        = (idx == LAST_IDX);
  assign tx_axis_tlast  = tx_axis_tvalid && at_last;
  assign hs             = tx_axis_tvalid && tx_axis_tready;
  assign busy           = tx_axis_tvalid || pending;

  // Everything past byte 23 is zero fill.
  assign hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq, snap_good, snap_bad};
  assign rev = 5'd23 - idx[4:0];

  always_comb begin
    tx_axis_tdata = 8'h00;
    if (tx_axis_tvalid && (idx < HDR_LEN))
      tx_axis_tdata = hdr[{rev, 3'b000} +: 8];
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    seq_n     = seq;
    snap_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (send_req || pending) begin
          state_n   = SEND;
          idx_n     = '0;
          pending_n = 1'b0;
          snap_en   = 1'b1;
        end
      end
      SEND: begin
        if (send_req)
          pending_n = 1'b1;
        if (hs) begin
          if (at_last) begin
            state_n = IDLE;
            seq_n   = seq + 16'd1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      seq       <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      snap_good <= '0;
      snap_bad  <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pending <= pending_n;
      seq     <= seq_n;
      if (snap_en) begin
        snap_good <= good_cnt;
        snap_bad  <= bad_cnt;
      end
      if (rx_good_frame && (good_cnt != '1))
        good_cnt <= good_cnt + 32'd1;
      if (rx_bad_frame && (bad_cnt != '1))
        bad_cnt <= bad_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_eth_status_tx.sv
// Self-checking bench for eth_status_tx.
// Frame-level reference model plus directed scenarios and random traffic.
module tb_eth_status_tx;

  localparam int LAST = 59;
  localparam int FLEN = 60;

  logic       clk_125 = 1'b0;
  logic       rst = 1'b0;
  logic       send_req = 1'b0;
  logic       rx_good_frame = 1'b0;
  logic       rx_bad_frame = 1'b0;
  logic       tx_axis_tready = 1'b1;
  logic [7:0] tx_axis_tdata;
  logic       tx_axis_tkeep;
  logic       tx_axis_tvalid;
  logic       tx_axis_tlast;
  logic       tx_axis_tuser;
  logic       busy;

  eth_status_tx dut (
    .clk_125        (clk_125),
    .rst            (rst),
    .send_req       (send_req),
    .rx_good_frame  (rx_good_frame),
    .rx_bad_frame   (rx_bad_frame),
    .tx_axis_tdata  (tx_axis_tdata),
    .tx_axis_tkeep  (tx_axis_tkeep),
    .tx_axis_tvalid (tx_axis_tvalid),
    .tx_axis_tready (tx_axis_tready),
    .tx_axis_tlast  (tx_axis_tlast),
    .tx_axis_tuser  (tx_axis_tuser),
    .busy           (busy)
  );

  always #4 clk_125 = ~clk_125;

  int n_cmp = 0;
  int n_bad = 0;
  int pcyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, pcyc);
    end
  endtask

  // Reference model: frame contents computed whole at launch time.
  longint     m_good, m_bad;
  logic [15:0] m_seq;
  bit         m_pend, m_act;
  int         m_idx;
  logic [7:0] m_frame [FLEN];

  function automatic void build_frame();
    logic [191:0] h;
    h = {48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88B5,
         m_seq, m_good[31:0], m_bad[31:0]};
    for (int i = 0; i < FLEN; i++)
      m_frame[i] = (i < 24) ? h[191 - 8*i -: 8] : 8'h00;
  endfunction

  initial forever begin
    @(posedge clk_125);
    pcyc++;
    if (rst) begin
      m_good = 0; m_bad = 0; m_seq = 0;
      m_pend = 0; m_act = 0; m_idx = 0;
    end else begin
      if (!m_act) begin
        if (send_req || m_pend) begin
          build_frame();
          m_act = 1; m_idx = 0; m_pend = 0;
        end
      end else begin
        if (send_req) m_pend = 1;
        if (tx_axis_tready) begin
          if (m_idx == LAST) begin
            m_act = 0;
            m_seq = m_seq + 16'd1;
          end else begin
            m_idx++;
          end
        end
      end
      if (rx_good_frame && m_good < 64'hFFFFFFFF) m_good++;
      if (rx_bad_frame && m_bad < 64'hFFFFFFFF) m_bad++;
    end
  end

  // Log of completed frames as observed on the bus.
  logic [7:0] fb[$];
  logic [7:0] cur[$];
  int fstart[$];
  int fend[$];
  int cur_start = 0;
  bit prev_valid = 0, prev_stall = 0;
  logic [7:0] prev_data = 0;
  logic prev_last = 0;

  initial forever begin
    @(negedge clk_125);
    #2;
    if (chk_en) begin
      chk("tvalid", 64'(tx_axis_tvalid), 64'(m_act));
      chk("tlast", 64'(tx_axis_tlast), 64'(m_act && m_idx == LAST));
      chk("busy", 64'(busy), 64'(m_act || m_pend));
      chk("tkeep", 64'(tx_axis_tkeep), 64'd1);
      chk("tuser", 64'(tx_axis_tuser), 64'd0);
      if (m_act)
        chk("tdata", 64'(tx_axis_tdata), 64'(m_frame[m_idx]));
      if (prev_stall) begin
        chk("stall_tdata", 64'(tx_axis_tdata), 64'(prev_data));
        chk("stall_tlast", 64'(tx_axis_tlast), 64'(prev_last));
      end
    end
    if (tx_axis_tvalid && !prev_valid) cur_start = pcyc;
    if (rst) begin
      cur.delete();
    end else if (tx_axis_tvalid && tx_axis_tready) begin
      cur.push_back(tx_axis_tdata);
      if (tx_axis_tlast) begin
        foreach (cur[i]) fb.push_back(cur[i]);
        cur.delete();
        fstart.push_back(cur_start);
        fend.push_back(pcyc);
      end
    end
    prev_valid = tx_axis_tvalid && !rst;
    prev_stall = tx_axis_tvalid && !tx_axis_tready && !rst;
    prev_data  = tx_axis_tdata;
    prev_last  = tx_axis_tlast;
  end

  task automatic clr_log();
    fb.delete(); fstart.delete(); fend.delete();
  endtask

  task automatic drive(input bit s, input bit g, input bit b);
    @(negedge clk_125);
    send_req = s; rx_good_frame = g; rx_bad_frame = b;
    @(negedge clk_125);
    send_req = 0; rx_good_frame = 0; rx_bad_frame = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_125);
    rst = 1; send_req = 0; rx_good_frame = 0; rx_bad_frame = 0;
    @(negedge clk_125);
    rst = 0;
    clr_log();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_125);
    while (busy && n < 2000) begin
      @(negedge clk_125);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
    @(negedge clk_125);
  endtask

  function automatic logic [31:0] fword(input int k, input int off);
    int b;
    b = k*FLEN + off;
    return {fb[b], fb[b+1], fb[b+2], fb[b+3]};
  endfunction

  task automatic chk_frame(input int k, input logic [15:0] s,
                           input logic [31:0] g, input logic [31:0] b);
    logic [191:0] h;
    h = {48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88B5, s, g, b};
    if (fend.size() > k) begin
      for (int i = 0; i < FLEN; i++)
        chk($sformatf("frame%0d_byte%0d", k, i), 64'(fb[k*FLEN + i]),
            64'((i < 24) ? h[191 - 8*i -: 8] : 8'h00));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] hdr1;
    int req_c;
    bit t;
    int nv;

    // Test 1: basic frame at full rate
    do_reset();
    chk_en = 1;
    chk("rst_tvalid", 64'(tx_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(tx_axis_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tx_axis_tready = 1;
    repeat (3) drive(0, 1, 0);
    drive(0, 0, 1);
    @(negedge clk_125);
    send_req = 1; req_c = pcyc;
    @(negedge clk_125);
    send_req = 0;
    wait_idle();
    chk("t1_nframes", 64'(fend.size()), 64'd1);
    hdr1 = 192'hFFFF_FFFF_FFFF_0200_0000_0001_88B5_0000_0000_0003_0000_0001;
    if (fend.size() >= 1) begin
      for (int i = 0; i < FLEN; i++)
        chk($sformatf("t1_byte%0d", i), 64'(fb[i]),
            64'((i < 24) ? hdr1[191 - 8*i -: 8] : 8'h00));
      chk("t1_latency", 64'(fstart[0] - req_c), 64'd1);
      chk("t1_duration", 64'(fend[0] - fstart[0] + 1), 64'd60);
    end

    // Test 2: same frame with tready alternating 1/0
    do_reset();
    repeat (3) drive(0, 1, 0);
    drive(0, 0, 1);
    tx_axis_tready = 0;
    @(negedge clk_125);
    send_req = 1;
    @(negedge clk_125);
    send_req = 0;
    t = 1;
    for (int i = 0; i < 400 && busy; i++) begin
      tx_axis_tready = t;
      t = ~t;
      @(negedge clk_125);
    end
    tx_axis_tready = 1;
    wait_idle();
    chk("t2_nframes", 64'(fend.size()), 64'd1);
    chk_frame(0, 16'h0000, 32'd3, 32'd1);
    if (fend.size() >= 1)
      chk("t2_duration", 64'(fend[0] - fstart[0] + 1), 64'd119);

    // Test 3: extra requests mid-frame and on the tlast cycle
    do_reset();
    drive(1, 0, 0);
    repeat (8) @(negedge clk_125);
    drive(1, 0, 0);
    repeat (8) @(negedge clk_125);
    drive(1, 0, 0);
    for (int i = 0; i < 200 && !tx_axis_tlast; i++) @(negedge clk_125);
    send_req = 1;
    @(negedge clk_125);
    send_req = 0;
    wait_idle();
    repeat (4) @(negedge clk_125);
    chk("t3_nframes", 64'(fend.size()), 64'd2);
    chk_frame(0, 16'h0000, 32'd0, 32'd0);
    chk_frame(1, 16'h0001, 32'd0, 32'd0);
    if (fend.size() >= 2)
      chk("t3_gap", 64'(fstart[1] - fend[0]), 64'd2);

    // Test 4: good counter saturation
    do_reset();
    @(negedge clk_125);
    force dut.good_cnt = 32'hFFFFFFFE;
    m_good = 64'hFFFFFFFE;
    #1;
    release dut.good_cnt;
    repeat (3) drive(0, 1, 0);
    drive(1, 0, 0);
    wait_idle();
    if (fend.size() >= 1)
      chk("t4_sat", 64'(fword(0, 16)), 64'hFFFFFFFF);
    chk_frame(0, 16'h0000, 32'hFFFFFFFF, 32'd0);

    // Test 5: pulse coinciding with request is not in the snapshot
    do_reset();
    repeat (5) drive(0, 1, 0);
    drive(1, 1, 0);
    wait_idle();
    drive(1, 0, 0);
    wait_idle();
    chk("t5_nframes", 64'(fend.size()), 64'd2);
    if (fend.size() >= 2) begin
      chk("t5_snap0", 64'(fword(0, 16)), 64'd5);
      chk("t5_snap1", 64'(fword(1, 16)), 64'd6);
    end

    // Test 6: reset mid-frame
    do_reset();
    repeat (2) drive(0, 1, 1);
    drive(1, 0, 0);
    nv = 0;
    for (int i = 0; i < 100 && nv < 20; i++) begin
      if (tx_axis_tvalid) nv++;
      @(negedge clk_125);
    end
    rst = 1;
    @(negedge clk_125);
    rst = 0;
    chk("t6_tvalid", 64'(tx_axis_tvalid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_nframes_abort", 64'(fend.size()), 64'd0);
    drive(1, 0, 0);
    wait_idle();
    chk("t6_nframes", 64'(fend.size()), 64'd1);
    chk_frame(0, 16'h0000, 32'd0, 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_125);
      send_req       = ($urandom_range(15) == 0);
      rx_good_frame  = ($urandom_range(3) == 0);
      rx_bad_frame   = ($urandom_range(7) == 0);
      tx_axis_tready = ($urandom_range(3) != 0);
      rst            = ($urandom_range(999) == 0);
    end
    @(negedge clk_125);
    send_req = 0; rx_good_frame = 0; rx_bad_frame = 0;
    rst = 0; tx_axis_tready = 1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
